// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU/LSU result handshakes, issue-side scoreboard
// query, flush, and the registered register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic            iss_stall;

    logic            flush;

    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  flush,
        output alu_ready, lsu_ready, iss_stall,
        output wb_wen, wb_rd, wb_data
    );

    // Pipeline / environment side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        output flush,
        input  alu_ready, lsu_ready, iss_stall,
        input  wb_wen, wb_rd, wb_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin arbitration between ALU and load results, one
// registered register-file write per cycle, and a busy scoreboard for issue hazards.
module wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    // Which source wins the next contended cycle.
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LSU = 1'b1
    } rr_e;

    rr_e             rr_q, rr_d;
    logic            grant_alu, grant_lsu;

    logic            wb_wen_q, wb_wen_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic [31:0]     busy_q, busy_d;
    logic            iss_stall;
    logic            iss_set;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        rr_d      = rr_q;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (rr_q == PRI_ALU) begin
                grant_alu = 1'b1;
                rr_d      = PRI_LSU;
            end else begin
                grant_lsu = 1'b1;
                rr_d      = PRI_ALU;
            end
        end else begin
            grant_alu = bus.alu_valid;
            grant_lsu = bus.lsu_valid;
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;

    // Writes to x0 still load rd/data but never raise the write enable.
    always_comb begin
        wb_wen_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (grant_alu) begin
            wb_wen_d  = (bus.alu_rd != 5'd0);
            wb_rd_d   = bus.alu_rd;
            wb_data_d = bus.alu_data;
        end else if (grant_lsu) begin
            wb_wen_d  = (bus.lsu_rd != 5'd0);
            wb_rd_d   = bus.lsu_rd;
            wb_data_d = bus.lsu_data;
        end
    end

    assign iss_stall     = busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd];
    assign bus.iss_stall = iss_stall;
    assign iss_set       = bus.iss_valid & ~iss_stall & (bus.iss_rd != 5'd0);

    // Clear lands on the same edge as the regfile commit; a same-edge set wins,
    // and flush beats both.
    always_comb begin
        busy_d = busy_q;
        if (wb_wen_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= PRI_ALU;
            wb_wen_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            wb_wen_q  <= wb_wen_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.wb_wen  = wb_wen_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run checked against
// a rule-level model of arbitration, write-port timing and the busy scoreboard.
module tb_wb_arbiter;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN)) bus ();
    wb_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
        bus.flush     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.iss_valid = 1'b1;
            bus.iss_rd  = 5'($urandom_range(0, 31));
            bus.iss_rs1 = 5'($urandom_range(0, 31));
            bus.iss_rs2 = 5'($urandom_range(0, 31));
            #1;
            n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", bus.iss_stall); else n_pass++;
            n_checks++; if (bus.wb_wen !== 1'b0) $display("FAIL rst_wen got %b exp 0", bus.wb_wen); else n_pass++;
            n_checks++; if (bus.wb_rd !== 5'd0) $display("FAIL rst_rd got %0d exp 0", bus.wb_rd); else n_pass++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.wb_wen !== 1'b0) $display("FAIL idle_wen got %b exp 0", bus.wb_wen); else n_pass++;
        end
    endtask

    task automatic test_single_alu();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'hDEAD;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) $display("FAIL single_alu_ready got %b exp 1", bus.alu_ready); else n_pass++;
        n_checks++; if (bus.lsu_ready !== 1'b0) $display("FAIL single_lsu_ready got %b exp 0", bus.lsu_ready); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        n_checks++; if (bus.wb_wen !== 1'b1) $display("FAIL single_wen got %b exp 1", bus.wb_wen); else n_pass++;
        n_checks++; if (bus.wb_rd !== 5'd5) $display("FAIL single_rd got %0d exp 5", bus.wb_rd); else n_pass++;
        n_checks++; if (bus.wb_data !== 64'hDEAD) $display("FAIL single_data got %h exp dead", bus.wb_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.wb_wen !== 1'b0) $display("FAIL single_wen_drop got %b exp 0", bus.wb_wen); else n_pass++;
        n_checks++; if (bus.wb_data !== 64'hDEAD) $display("FAIL single_data_hold got %h exp dead", bus.wb_data); else n_pass++;
    endtask

    task automatic test_contention();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 64'hA1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 64'hB2;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) $display("FAIL rr1_alu_ready got %b exp 1", bus.alu_ready); else n_pass++;
        n_checks++; if (bus.lsu_ready !== 1'b0) $display("FAIL rr1_lsu_ready got %b exp 0", bus.lsu_ready); else n_pass++;
        @(posedge clk); #1;
        bus.alu_rd = 5'd1; bus.alu_data = 64'hA3;
        n_checks++; if (bus.wb_rd !== 5'd1 || bus.wb_data !== 64'hA1 || bus.wb_wen !== 1'b1)
            $display("FAIL rr1_wb got %b/%0d/%h exp 1/1/a1", bus.wb_wen, bus.wb_rd, bus.wb_data); else n_pass++;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b0) $display("FAIL rr2_alu_ready got %b exp 0", bus.alu_ready); else n_pass++;
        n_checks++; if (bus.lsu_ready !== 1'b1) $display("FAIL rr2_lsu_ready got %b exp 1", bus.lsu_ready); else n_pass++;
        @(posedge clk); #1;
        bus.lsu_rd = 5'd4; bus.lsu_data = 64'hC4;
        n_checks++; if (bus.wb_rd !== 5'd2 || bus.wb_data !== 64'hB2 || bus.wb_wen !== 1'b1)
            $display("FAIL rr2_wb got %b/%0d/%h exp 1/2/b2", bus.wb_wen, bus.wb_rd, bus.wb_data); else n_pass++;
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) $display("FAIL rr3_alu_ready got %b exp 1", bus.alu_ready); else n_pass++;
        n_checks++; if (bus.lsu_ready !== 1'b0) $display("FAIL rr3_lsu_ready got %b exp 0", bus.lsu_ready); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        n_checks++; if (bus.wb_rd !== 5'd1 || bus.wb_data !== 64'hA3 || bus.wb_wen !== 1'b1)
            $display("FAIL rr3_wb got %b/%0d/%h exp 1/1/a3", bus.wb_wen, bus.wb_rd, bus.wb_data); else n_pass++;
    endtask

    task automatic test_raw();
        apply_reset();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL raw_issue_stall got %b exp 0", bus.iss_stall); else n_pass++;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd7;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL raw_stall_n got %b exp 1", bus.iss_stall); else n_pass++;
        n_checks++; if (bus.alu_ready !== 1'b1) $display("FAIL raw_alu_ready got %b exp 1", bus.alu_ready); else n_pass++;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd7) $display("FAIL raw_wb got %b/%0d exp 1/7", bus.wb_wen, bus.wb_rd); else n_pass++;
        n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL raw_stall_n1 got %b exp 1", bus.iss_stall); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL raw_stall_n2 got %b exp 0", bus.iss_stall); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_same_edge();
        apply_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h33;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        #1;
        n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_rd !== 5'd3) $display("FAIL same_wb got %b/%0d exp 1/3", bus.wb_wen, bus.wb_rd); else n_pass++;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL same_issue_stall got %b exp 0", bus.iss_stall); else n_pass++;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd3;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL same_set_wins got %b exp 1", bus.iss_stall); else n_pass++;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL x0_busy got %b exp 0", bus.iss_stall); else n_pass++;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 64'h55;
        #1;
        n_checks++; if (bus.lsu_ready !== 1'b1) $display("FAIL x0_lsu_ready got %b exp 1", bus.lsu_ready); else n_pass++;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        n_checks++; if (bus.wb_wen !== 1'b0) $display("FAIL x0_wen got %b exp 0", bus.wb_wen); else n_pass++;
        n_checks++; if (bus.wb_rd !== 5'd0 || bus.wb_data !== 64'h55) $display("FAIL x0_wb got %0d/%h exp 0/55", bus.wb_rd, bus.wb_data); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_flush_reset();
        apply_reset();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        @(posedge clk); #1;
        bus.iss_rd = 5'd9;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL flush_issue9_stall got %b exp 0", bus.iss_stall); else n_pass++;
        @(posedge clk); #1;
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd4; bus.iss_rs2 = 5'd9;
        bus.flush = 1'b1;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b1) $display("FAIL flush_busy_before got %b exp 1", bus.iss_stall); else n_pass++;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) $display("FAIL flush_busy_after got %b exp 0", bus.iss_stall); else n_pass++;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 64'h1010;
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        n_checks++; if (bus.wb_wen !== 1'b1) $display("FAIL midrst_wen_pre got %b exp 1", bus.wb_wen); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.wb_wen !== 1'b0) $display("FAIL midrst_wen got %b exp 0", bus.wb_wen); else n_pass++;
        n_checks++; if (bus.wb_rd !== 5'd0 || bus.wb_data !== '0) $display("FAIL midrst_wb got %0d/%h exp 0/0", bus.wb_rd, bus.wb_data); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
    endtask

    // Model: ready follows the round-robin rule, the write port shows the winner
    // one cycle later, and busy bits track issued-but-uncommitted destinations.
    task automatic test_random();
        bit             mbusy[32];
        bit             ewen;
        logic [4:0]     erd;
        logic [63:0]    edata;
        int             last_win;
        bit             a_v, l_v, ga, gl, stall, both, iv, fl;
        logic [4:0]     a_rd, l_rd, ird, irs1, irs2;
        logic [63:0]    a_d, l_d;
        apply_reset();
        foreach (mbusy[k]) mbusy[k] = 1'b0;
        ewen = 1'b0; erd = 5'd0; edata = '0; last_win = 1;
        a_v = 1'b0; l_v = 1'b0; a_rd = 5'd0; l_rd = 5'd0; a_d = '0; l_d = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!a_v && $urandom_range(0, 2) != 0) begin
                a_v = 1'b1; a_rd = 5'($urandom_range(0, 7)); a_d = {$urandom, $urandom};
            end
            if (!l_v && $urandom_range(0, 2) != 0) begin
                l_v = 1'b1; l_rd = 5'($urandom_range(0, 7)); l_d = {$urandom, $urandom};
            end
            iv   = 1'($urandom_range(0, 1));
            ird  = 5'($urandom_range(0, 7));
            irs1 = 5'($urandom_range(0, 7));
            irs2 = 5'($urandom_range(0, 7));
            fl   = ($urandom_range(0, 9) == 0);
            bus.alu_valid = a_v; bus.alu_rd = a_rd; bus.alu_data = a_d;
            bus.lsu_valid = l_v; bus.lsu_rd = l_rd; bus.lsu_data = l_d;
            bus.iss_valid = iv; bus.iss_rd = ird; bus.iss_rs1 = irs1; bus.iss_rs2 = irs2;
            bus.flush = fl;
            #1;
            ga    = a_v && (!l_v || last_win == 1);
            gl    = l_v && !ga;
            stall = mbusy[irs1] | mbusy[irs2] | mbusy[ird];
            n_checks++; if (bus.alu_ready !== ga) $display("FAIL rnd_alu_ready cyc %0d got %b exp %b", cyc, bus.alu_ready, ga); else n_pass++;
            n_checks++; if (bus.lsu_ready !== gl) $display("FAIL rnd_lsu_ready cyc %0d got %b exp %b", cyc, bus.lsu_ready, gl); else n_pass++;
            n_checks++; if (bus.iss_stall !== stall) $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, bus.iss_stall, stall); else n_pass++;
            if (ewen) mbusy[erd] = 1'b0;
            if (iv && !stall && ird != 5'd0) mbusy[ird] = 1'b1;
            if (fl) foreach (mbusy[k]) mbusy[k] = 1'b0;
            both = a_v && l_v;
            if (both) last_win = ga ? 0 : 1;
            if (ga) begin
                ewen = (a_rd != 5'd0); erd = a_rd; edata = a_d; a_v = 1'b0;
            end else if (gl) begin
                ewen = (l_rd != 5'd0); erd = l_rd; edata = l_d; l_v = 1'b0;
            end else begin
                ewen = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++; if (bus.wb_wen !== ewen) $display("FAIL rnd_wen cyc %0d got %b exp %b", cyc, bus.wb_wen, ewen); else n_pass++;
            n_checks++; if (bus.wb_rd !== erd) $display("FAIL rnd_rd cyc %0d got %0d exp %0d", cyc, bus.wb_rd, erd); else n_pass++;
            n_checks++; if (bus.wb_data !== edata) $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, bus.wb_data, edata); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_raw();
        test_same_edge();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
